// File: rtl/mem_arbiter.sv
// Shared-slave arbiter: one master at a time gets a single transfer, chosen round-robin or by fixed priority.
// Latency: one grant cycle plus at least one XFER cycle; done/err pulse combinationally in the last XFER cycle.
// Backpressure: masters held via m_stall until done/err; slave stalls via s_ready, aborted after TIMEOUT cycles.
module mem_arbiter #(
    parameter int NUM_M   = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_M-1:0]        m_req,
    input  logic [NUM_M*ADDR_W-1:0] m_addr,
    input  logic [NUM_M-1:0]        m_write,
    input  logic [NUM_M*DATA_W-1:0] m_wdata,
    output logic [NUM_M-1:0]        m_stall,
    output logic [NUM_M-1:0]        m_done,
    output logic [NUM_M-1:0]        m_err,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    s_valid,
    output logic [ADDR_W-1:0]       s_addr,
    output logic                    s_write,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic                    s_ready,
    input  logic [DATA_W-1:0]       s_rdata,
    output logic                    busy
);
    localparam int              IDX_W   = $clog2(NUM_M);
    localparam logic [IDX_W:0]  NUM_M_W = (IDX_W+1)'(NUM_M);
    localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    win_q;
    logic [7:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                grant_vld;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W:0]      cand;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_write;
    logic [DATA_W-1:0]   sel_wdata;
    logic                done_any;
    logic                err_any;
    logic                xfer_end;
    logic [IDX_W-1:0]    ptr_d;

    // Search upward from ptr_q with wrap; fixed-priority mode keeps ptr_q at 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_M; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= NUM_M_W) begin
                cand = cand - NUM_M_W;
            end
            if (!grant_vld && m_req[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_write = m_write[i];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Completion beats timeout when s_ready arrives on the last allowed cycle.
    assign done_any = (state_q == XFER) && s_ready;
    assign err_any  = (state_q == XFER) && !s_ready && (cnt_q == TO_LAST);
    assign xfer_end = done_any || err_any;

    always_comb begin
        m_done = '0;
        m_err  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            m_done[i] = done_any && (win_q == IDX_W'(i));
            m_err[i]  = err_any  && (win_q == IDX_W'(i));
        end
    end

    always_comb begin
        ptr_d = '0;
        if (RR_MODE != 0) begin
            ptr_d = (win_q == IDX_W'(NUM_M - 1)) ? '0 : win_q + IDX_W'(1);
        end
    end

    assign m_stall = m_req & ~m_done & ~m_err;
    assign m_rdata = done_any ? s_rdata : '0;
    assign s_valid = (state_q == XFER);
    assign busy    = (state_q == XFER);
    assign s_addr  = addr_q;
    assign s_write = write_q;
    assign s_wdata = wdata_q;

    // Latched slave fields are cleared on exit so they read zero outside XFER.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        state_q <= XFER;
                        win_q   <= grant_idx;
                        cnt_q   <= '0;
                        addr_q  <= sel_addr;
                        write_q <= sel_write;
                        wdata_q <= sel_wdata;
                    end
                end
                XFER: begin
                    if (xfer_end) begin
                        state_q <= IDLE;
                        ptr_q   <= ptr_d;
                        addr_q  <= '0;
                        write_q <= 1'b0;
                        wdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
